prog_sequencer: RTL

PROG_SEQUENCER -- requirements
Module: prog_sequencer

---
 rtl/prog_sequencer_if.sv | 56 +++++
 rtl/prog_sequencer.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/prog_sequencer_if.sv
// ---------------------------------------------------------------------------
// prog_sequencer_if
//
// Purpose: groups the host/decoder-facing signals of the program sequencer
// into one bundle so the sequencer and its environment connect in one step.
//
// Signals (directions seen from the sequencer, i.e. the slave modport):
//   Req           in   level start request from the host
//   JumpEqual     in   decoded je
//   JumpNotEqual  in   decoded jne
//   Zero          in   ALU zero flag for the current compare
//   BranchTarget  in   absolute jump target (PC_W bits)
//   LoadInst      in   current instruction reads data memory
//   StoreInst     in   current instruction writes data memory
//   HaltInst      in   current instruction is the done instruction
//   ProgCtr       out  instruction ROM address (PC_W bits)
//   IrLoad        out  capture ROM output into the instruction register
//   RegWrGate     out  qualifies the register-file write enable
//   MemWrGate     out  qualifies the data-memory write enable
//   Ack           out  program finished
//   Timeout       out  halt was caused by the instruction budget
//   InstrCount    out  instructions retired since the last start (16 bits)
//
// Modports: master = host/decoder side, slave = sequencer side.
// ---------------------------------------------------------------------------
interface prog_sequencer_if #(
  parameter int PC_W = 10
);
  logic            Req;
  logic            JumpEqual;
  logic            JumpNotEqual;
  logic            Zero;
  logic [PC_W-1:0] BranchTarget;
  logic            LoadInst;
  logic            StoreInst;
  logic            HaltInst;
  logic [PC_W-1:0] ProgCtr;
  logic            IrLoad;
  logic            RegWrGate;
  logic            MemWrGate;
  logic            Ack;
  logic            Timeout;
  logic [15:0]     InstrCount;

  modport master (
    output Req, JumpEqual, JumpNotEqual, Zero, BranchTarget,
           LoadInst, StoreInst, HaltInst,
    input  ProgCtr, IrLoad, RegWrGate, MemWrGate, Ack, Timeout, InstrCount
  );

  modport slave (
    input  Req, JumpEqual, JumpNotEqual, Zero, BranchTarget,
           LoadInst, StoreInst, HaltInst,
    output ProgCtr, IrLoad, RegWrGate, MemWrGate, Ack, Timeout, InstrCount
  );
endinterface

// File: rtl/prog_sequencer.sv
// ---------------------------------------------------------------------------
// prog_sequencer
//
// Purpose: multi-cycle control sequencer for a small processor. It walks the
// program counter through FETCH / EXEC (/ MEM for loads), gates register and
// data-memory writes, counts retired instructions and stops either on the
// halt instruction or when the instruction budget runs out.
//
// Parameters:
//   PC_W        program counter width
//   START_ADDR  PC loaded on every program start
//   MAX_INSTR   retire count that forces a halt with Timeout set
//
// Ports:
//   Clk    in  sole clock, rising edge
//   Reset  in  synchronous, active-low reset
//   bus    slave side of prog_sequencer_if (see that file for the signals)
// ---------------------------------------------------------------------------
module prog_sequencer #(
  parameter int              PC_W       = 10,
  parameter logic [PC_W-1:0] START_ADDR = '0,
  parameter logic [15:0]     MAX_INSTR  = 16'hFFFF
) (
  input  logic             Clk,
  input  logic             Reset,
  prog_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_MEM,
    S_HALT
  } state_t;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0]     cnt_q, cnt_d;
  logic            timeout_q, timeout_d;
  logic            ack_q, ack_d;
  logic            ir_load_q, ir_load_d;
  logic            mem_rd_q, mem_rd_d;   // high for the whole MEM cycle

  logic            taken;
  logic            retire;
  logic            budget_hit;
  logic [PC_W-1:0] pc_retire;
  logic [15:0]     cnt_retire;
  logic            in_exec;
  logic            reg_wr_exec;
  logic            mem_wr_exec;

  // Instruction-level decode shared by EXEC and MEM retirement.
  always_comb begin
    taken      = (bus.JumpEqual & bus.Zero) | (bus.JumpNotEqual & ~bus.Zero);
    pc_retire  = taken ? bus.BranchTarget : pc_q + PC_W'(1);
    cnt_retire = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
    // Widened compare so a saturated count never aliases onto MAX_INSTR.
    budget_hit = (17'(cnt_q) + 17'd1) == 17'(MAX_INSTR);

    in_exec    = (state_q == S_EXEC);
    // Halt beats everything, load beats store; loads retire from MEM instead.
    retire     = (in_exec & ~bus.HaltInst & ~bus.LoadInst) | (state_q == S_MEM);

    // EXEC gates are decoded straight from the current instruction flags.
    reg_wr_exec = in_exec & ~bus.HaltInst & ~bus.LoadInst & ~bus.StoreInst
                & ~bus.JumpEqual & ~bus.JumpNotEqual;
    mem_wr_exec = in_exec & ~bus.HaltInst & ~bus.LoadInst & bus.StoreInst;
  end

  // Next-state and next-register computation.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;

    case (state_q)
      S_IDLE: begin
        if (bus.Req) begin
          state_d   = S_FETCH;
          pc_d      = START_ADDR;
          cnt_d     = 16'd0;
          timeout_d = 1'b0;
        end
      end
      S_FETCH: state_d = S_EXEC;
      S_EXEC: begin
        if (bus.HaltInst) begin
          state_d = S_HALT;
        end else if (bus.LoadInst) begin
          state_d = S_MEM;
        end
      end
      S_MEM: state_d = S_MEM;   // retirement below moves us on
      S_HALT: begin
        // Leaving HALT needs Req low, so a held Req cannot auto-restart.
        if (!bus.Req) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (retire) begin
      pc_d  = pc_retire;
      cnt_d = cnt_retire;
      if (budget_hit) begin
        state_d   = S_HALT;
        timeout_d = 1'b1;
      end else begin
        state_d = S_FETCH;
      end
    end
  end

  // Moore outputs are registered from the upcoming state so they line up
  // exactly with the state they belong to.
  always_comb begin
    ir_load_d = (state_d == S_FETCH);
    ack_d     = (state_d == S_HALT);
    mem_rd_d  = (state_d == S_MEM);
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q   <= S_IDLE;
      pc_q      <= START_ADDR;
      cnt_q     <= 16'd0;
      timeout_q <= 1'b0;
      ack_q     <= 1'b0;
      ir_load_q <= 1'b0;
      mem_rd_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
      ack_q     <= ack_d;
      ir_load_q <= ir_load_d;
      mem_rd_q  <= mem_rd_d;
    end
  end

  // MEM and EXEC are exclusive states, so the two gates can never overlap.
  assign bus.ProgCtr    = pc_q;
  assign bus.IrLoad     = ir_load_q;
  assign bus.RegWrGate  = mem_rd_q | reg_wr_exec;
  assign bus.MemWrGate  = mem_wr_exec;
  assign bus.Ack        = ack_q;
  assign bus.Timeout    = timeout_q;
  assign bus.InstrCount = cnt_q;

endmodule
